spi_cs_router: RTL and testbench
================================

Name: spi_cs_router

Overview:
- Registered, parametrised 1-to-N chip-select router for the SPI master subsystem.
- Routes one master chip-select (or any serial strobe) to one of N_CH channel outputs. Every non-selected channel is held at the idle level `deflt`.
- Channel switches are made glitch-free:
  - the router waits for the in-flight transaction to end (`in` back to `deflt`);
  - it then forces all channels idle for a programmable guard interval;
  - only then does it connect the new channel.
- Sits between the SPI master engine and the board chip-select pins.

Parameters:
- N_CH, 8, number of output channels (2..256).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= N_CH.
- GUARD_CYC, 2, number of all-idle cycles inserted between disconnect and connect (0..255).

Ports:
- clk  input  1  system clock.
- rstb  input  1  asynchronous active-low reset.
- sel  input  SEL_W  requested channel index; sampled only when sel_load=1.
- sel_load  input  1  one-cycle strobe: request a switch to `sel`.
- in  input  1  signal to route.
- deflt  input  1  idle level for non-selected channels.
- out  output  N_CH  registered channel outputs.
- cur_sel  output  SEL_W  index of the currently connected channel.
- connected  output  1  high when a channel is connected (state CONN).
- switching  output  1  high while a switch is pending (DRAIN or GUARD).
- sel_err  output  1  one-cycle pulse when sel_load is accepted with sel >= N_CH.

Behaviour:
- Reset (rstb=0, async):
  - state=IDLE; out={N_CH{1'b1}}; cur_sel=0; pend_sel=0; guard count=0.
  - connected=0; switching=0; sel_err=0.
- All outputs are registered, and out has 1-cycle latency: out[k](t+1)=in(t) when channel k is routed at t, otherwise deflt(t).
- States:
  - IDLE: no channel routed; out=all deflt.
  - CONN: channel cur_sel routed.
  - DRAIN: old channel cur_sel still routed; waiting for in==deflt.
  - GUARD: out=all deflt; counter running.
- sel validity:
  - sel_load with sel>=N_CH: sel_err=1 next cycle only. State, pend_sel and cur_sel are unchanged, and the request is otherwise ignored.
- Transitions on a valid sel_load:
  - IDLE:
    - pend_sel=sel.
    - If GUARD_CYC=0: go to CONN.
    - Otherwise go to GUARD with count=GUARD_CYC.
  - CONN, sel==cur_sel: no action; no glitch on out.
  - CONN, sel!=cur_sel: pend_sel=sel.
    - If in==deflt in the same cycle: go to GUARD (or straight to CONN with the new channel when GUARD_CYC=0).
    - Otherwise go to DRAIN.
  - DRAIN or GUARD: pend_sel=sel (latest request wins). The state and the guard count are unchanged.
- Non-request transitions:
  - DRAIN: when in==deflt, go to GUARD (count=GUARD_CYC), or to CONN if GUARD_CYC=0. There is no timeout.
  - GUARD: decrement count each cycle; on the cycle count==1, go to CONN. GUARD therefore lasts exactly GUARD_CYC cycles.
  - On entry to CONN: cur_sel=pend_sel.
- Status outputs are registered with the state:
  - connected=1 only in CONN.
  - switching=1 only in DRAIN and GUARD.
- Simultaneity:
  - sel_load on the same cycle as the GUARD exit: the new pend_sel value is the one used for the CONN entry.
  - The channel update and the GUARD exit take effect together.
- Mid-operation reset: returns immediately to the reset values. A pending switch is discarded.
- deflt may change at any time; idle channels follow it with 1-cycle latency.

Test Plan:
1. Reset, deflt=1, GUARD_CYC=2 → out=8'hFF, connected=0, cur_sel=0.
2. sel_load with sel=5 from IDLE → switching=1 for 2 cycles; then connected=1, cur_sel=5. Driving in=0 gives out=8'hDF one cycle later.
3. While CONN on channel 5 with in=0, sel_load with sel=2:
   - DRAIN: out[5] keeps following in while switching=1.
   - Release in=1: out=8'hFF for 2 cycles.
   - Then cur_sel=2; in=0 gives out=8'hFB.
4. sel_load with sel=9 on N_CH=8 with SEL_W=4 → sel_err pulses one cycle; state and cur_sel unchanged.
5. During GUARD, sel_load with sel=7 overrides a pending sel=3 → CONN with cur_sel=7. Repeat with GUARD_CYC=0: connects on the cycle after in==deflt, with no all-idle cycle.
6. Assert rstb=0 mid-DRAIN → out=8'hFF, switching=0, connected=0 asynchronously. Also: sel_load with sel==cur_sel while in toggles → out unchanged, with no idle glitch.

Source files
------------

// File: rtl/spi_cs_router.sv
// Registered 1-to-N chip-select router with glitch-free channel switching.
// A switch first waits for the active strobe to return idle, then holds all channels idle for a guard interval.
module spi_cs_router #(
  parameter int N_CH      = 8,
  parameter int SEL_W     = 3,
  parameter int GUARD_CYC = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_load,
  input  logic             in,
  input  logic             deflt,
  output logic [N_CH-1:0]  out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             connected,
  output logic             switching,
  output logic             sel_err
);

  typedef enum logic [1:0] {IDLE, CONN, DRAIN, GUARD} state_t;

  localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYC);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic             connected_q, connected_d;
  logic             switching_q, switching_d;
  logic             sel_err_q, sel_err_d;
  logic [31:0]      sel_ext;
  logic             sel_valid;
  logic             load_ok;
  logic             routed;

  assign sel_ext   = 32'(sel);
  assign sel_valid = sel_ext < 32'(N_CH);
  assign load_ok   = sel_load && sel_valid;
  // The old channel keeps following `in` while draining so the transfer ends cleanly.
  assign routed    = (state_q == CONN) || (state_q == DRAIN);

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    cnt_d      = cnt_q;
    sel_err_d  = sel_load && !sel_valid;
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          pend_sel_d = sel;
          if (GUARD_CYC == 0) begin
            state_d   = CONN;
            cur_sel_d = sel;
          end else begin
            state_d = GUARD;
            cnt_d   = GUARD_INIT;
          end
        end
      end
      CONN: begin
        if (load_ok && (sel != cur_sel_q)) begin
          pend_sel_d = sel;
          if (in == deflt) begin
            if (GUARD_CYC == 0) begin
              cur_sel_d = sel;
            end else begin
              state_d = GUARD;
              cnt_d   = GUARD_INIT;
            end
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (load_ok) pend_sel_d = sel;
        if (in == deflt) begin
          if (GUARD_CYC == 0) begin
            state_d   = CONN;
            cur_sel_d = pend_sel_d;
          end else begin
            state_d = GUARD;
            cnt_d   = GUARD_INIT;
          end
        end
      end
      GUARD: begin
        // A request landing on the exit cycle is the one that gets connected.
        if (load_ok) pend_sel_d = sel;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d   = CONN;
          cur_sel_d = pend_sel_d;
          cnt_d     = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    connected_d = (state_d == CONN);
    switching_d = (state_d == DRAIN) || (state_d == GUARD);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign out_d[gi] = (routed && (cur_sel_q == SEL_W'(gi))) ? in : deflt;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      cur_sel_q   <= '0;
      pend_sel_q  <= '0;
      cnt_q       <= 8'd0;
      out_q       <= '1;
      connected_q <= 1'b0;
      switching_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      connected_q <= connected_d;
      switching_q <= switching_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out       = out_q;
  assign cur_sel   = cur_sel_q;
  assign connected = connected_q;
  assign switching = switching_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_spi_cs_router.sv
// Directed scoreboard bench for spi_cs_router: one instance with a 2-cycle guard, one with no guard.
module tb_spi_cs_router;

  logic       clk;
  logic       rstb;
  logic [3:0] sel, sel0;
  logic       sel_load, sel_load0;
  logic       in, in0;
  logic       deflt, deflt0;
  logic [7:0] out, out0;
  logic [3:0] cur_sel, cur_sel0;
  logic       connected, connected0;
  logic       switching, switching0;
  logic       sel_err, sel_err0;

  spi_cs_router #(.N_CH(8), .SEL_W(4), .GUARD_CYC(2)) dut (
    .clk(clk), .rstb(rstb), .sel(sel), .sel_load(sel_load), .in(in), .deflt(deflt),
    .out(out), .cur_sel(cur_sel), .connected(connected), .switching(switching), .sel_err(sel_err)
  );

  spi_cs_router #(.N_CH(8), .SEL_W(4), .GUARD_CYC(0)) dut0 (
    .clk(clk), .rstb(rstb), .sel(sel0), .sel_load(sel_load0), .in(in0), .deflt(deflt0),
    .out(out0), .cur_sel(cur_sel0), .connected(connected0), .switching(switching0), .sel_err(sel_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  localparam int S_OUT = 0, S_CUR = 1, S_CON = 2, S_SW = 3, S_ERR = 4;
  localparam int S_OUT0 = 10, S_CUR0 = 11, S_CON0 = 12, S_SW0 = 13;

  function automatic logic [31:0] get_obs(input int sig);
    case (sig)
      S_OUT:   return 32'(out);
      S_CUR:   return 32'(cur_sel);
      S_CON:   return 32'(connected);
      S_SW:    return 32'(switching);
      S_ERR:   return 32'(sel_err);
      S_OUT0:  return 32'(out0);
      S_CUR0:  return 32'(cur_sel0);
      S_CON0:  return 32'(connected0);
      S_SW0:   return 32'(switching0);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  // Expected status of the guarded instance in one call.
  task automatic push_main(input string tag, input logic [7:0] o, input logic [3:0] cs,
                           input logic con, input logic sw, input logic err);
    push({tag, ".out"}, S_OUT, 32'(o));
    push({tag, ".cur_sel"}, S_CUR, 32'(cs));
    push({tag, ".connected"}, S_CON, 32'(con));
    push({tag, ".switching"}, S_SW, 32'(sw));
    push({tag, ".sel_err"}, S_ERR, 32'(err));
  endtask

  task automatic push_g0(input string tag, input logic [7:0] o, input logic [3:0] cs,
                         input logic con, input logic sw);
    push({tag, ".out0"}, S_OUT0, 32'(o));
    push({tag, ".cur_sel0"}, S_CUR0, 32'(cs));
    push({tag, ".connected0"}, S_CON0, 32'(con));
    push({tag, ".switching0"}, S_SW0, 32'(sw));
  endtask

  task automatic check_pending();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = get_obs(e.sig);
      total_cnt = total_cnt + 1;
      assert (obs === e.exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_pending();
    $display("t=%0t out=%h cur=%0d con=%b sw=%b err=%b | out0=%h cur0=%0d con0=%b sw0=%b",
             $time, out, cur_sel, connected, switching, sel_err, out0, cur_sel0, connected0, switching0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b0; sel = 4'd0; sel_load = 1'b0; in = 1'b1; deflt = 1'b1;
    sel0 = 4'd0; sel_load0 = 1'b0; in0 = 1'b1; deflt0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_main("reset", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
    push_g0("reset", 8'hFF, 4'd0, 1'b0, 1'b0);
    check_pending();
    rstb = 1'b1;

    // Idle channels track deflt.
    deflt = 1'b0;
    push("idle_deflt0", S_OUT, 32'h00);
    step();
    deflt = 1'b1;
    push("idle_deflt1", S_OUT, 32'hFF);
    step();

    // IDLE -> GUARD(2) -> CONN on channel 5; GUARD_CYC=0 instance connects channel 1 at once.
    sel = 4'd5; sel_load = 1'b1;
    sel0 = 4'd1; sel_load0 = 1'b1;
    push_main("t2_guard1", 8'hFF, 4'd0, 1'b0, 1'b1, 1'b0);
    push_g0("g0_conn1", 8'hFF, 4'd1, 1'b1, 1'b0);
    step();
    sel_load = 1'b0; sel_load0 = 1'b0;
    push_main("t2_guard2", 8'hFF, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    in0 = 1'b0;
    push_main("t2_conn", 8'hFF, 4'd5, 1'b1, 1'b0, 1'b0);
    push("g0_route1", S_OUT0, 32'hFD);
    step();
    in = 1'b0;
    push_main("t2_route", 8'hDF, 4'd5, 1'b1, 1'b0, 1'b0);
    step();

    // Switch request while busy: drain, guard, connect channel 2.
    sel = 4'd2; sel_load = 1'b1;
    sel0 = 4'd4; sel_load0 = 1'b1;
    push_main("t3_drain1", 8'hDF, 4'd5, 1'b0, 1'b1, 1'b0);
    push_g0("g0_drain", 8'hFD, 4'd1, 1'b0, 1'b1);
    step();
    sel_load = 1'b0; sel_load0 = 1'b0;
    in0 = 1'b1;
    push_main("t3_drain2", 8'hDF, 4'd5, 1'b0, 1'b1, 1'b0);
    push_g0("g0_conn4", 8'hFF, 4'd4, 1'b1, 1'b0);
    step();
    in = 1'b1;
    in0 = 1'b0;
    push_main("t3_release", 8'hFF, 4'd5, 1'b0, 1'b1, 1'b0);
    push("g0_route4", S_OUT0, 32'hEF);
    step();
    push_main("t3_guard", 8'hFF, 4'd5, 1'b0, 1'b1, 1'b0);
    step();
    push_main("t3_conn", 8'hFF, 4'd2, 1'b1, 1'b0, 1'b0);
    step();
    in = 1'b0;
    push_main("t3_route", 8'hFB, 4'd2, 1'b1, 1'b0, 1'b0);
    step();

    // Out-of-range select.
    sel = 4'd9; sel_load = 1'b1;
    push_main("t4_err", 8'hFB, 4'd2, 1'b1, 1'b0, 1'b1);
    step();
    sel_load = 1'b0;
    push_main("t4_after", 8'hFB, 4'd2, 1'b1, 1'b0, 1'b0);
    step();

    // Idle-time switch to 3, overridden by 7 on the guard exit cycle.
    in = 1'b1;
    sel = 4'd3; sel_load = 1'b1;
    push_main("t5_guard1", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    sel_load = 1'b0;
    push_main("t5_guard2", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
    step();
    sel = 4'd7; sel_load = 1'b1;
    push_main("t5_conn7", 8'hFF, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    sel_load = 1'b0;
    in = 1'b0;
    push_main("t5_route", 8'h7F, 4'd7, 1'b1, 1'b0, 1'b0);
    step();

    // Reselecting the current channel while in toggles: no idle glitch.
    in = 1'b1; sel = 4'd7; sel_load = 1'b1;
    push_main("t6_same_hi", 8'hFF, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    in = 1'b0;
    push_main("t6_same_lo", 8'h7F, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    sel_load = 1'b0;

    // Asynchronous reset in the middle of a drain.
    sel = 4'd1; sel_load = 1'b1;
    push_main("t6_drain", 8'h7F, 4'd7, 1'b0, 1'b1, 1'b0);
    step();
    sel_load = 1'b0;
    #2;
    rstb = 1'b0;
    #1;
    push_main("t6_async_rst", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
    check_pending();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    push_main("t6_post_rst", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
    step();

    if (sb_q.size() != 0) begin
      total_cnt = total_cnt + 1;
      $display("FAIL scoreboard: observed %0d leftover entries expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
